// File: rtl/router_pkt_rx.sv
// Packet receiver for one router destination port; drains a single destination FIFO.
//
// Reads one packet at a time: a header byte (addr = [1:0], payload length = [7:2]),
// `len` payload bytes, then a trailing parity byte. The parity byte is the XOR of the
// header and all payload bytes. Payload is streamed out one byte per rx_valid pulse.
// The FIFO's data_out is valid in the cycle after an accepted read.
//
// Ports:
//   clock, resetn      rising-edge clock, asynchronous active-low reset
//   vld_out            FIFO not-empty
//   data_in            FIFO data_out
//   sink_stall         downstream back-pressure; blocks new reads only
//   read_enb           FIFO read strobe (combinational)
//   rx_data/valid/sop/eop  payload stream
//   rx_len, rx_addr    fields of the current/last header
//   pkt_done           packet complete pulse, with parity_err / addr_err
//   trunc_err          pulse when a packet is abandoned on starvation timeout
//   busy               receiver is inside a packet
module router_pkt_rx #(
  parameter logic [1:0]  MY_ADDR = 2'd0,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       vld_out,
  input  logic [7:0] data_in,
  input  logic       sink_stall,
  output logic       read_enb,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_sop,
  output logic       rx_eop,
  output logic [5:0] rx_len,
  output logic [1:0] rx_addr,
  output logic       pkt_done,
  output logic       parity_err,
  output logic       addr_err,
  output logic       trunc_err,
  output logic       busy
);

  localparam logic [7:0] ToLast = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StHdr, StBody} state_e;

  state_e     state_q, state_d;
  logic [6:0] issue_cnt_q, issue_cnt_d;  // reads still to issue (payload + parity)
  logic [6:0] recv_cnt_q, recv_cnt_d;    // bytes still to receive
  logic [7:0] par_q, par_d;
  logic [7:0] to_cnt_q, to_cnt_d;
  logic       pend_q, pend_d;            // a body read was accepted last cycle
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_sop_q, rx_sop_d;
  logic       rx_eop_q, rx_eop_d;
  logic [5:0] rx_len_q, rx_len_d;
  logic [1:0] rx_addr_q, rx_addr_d;
  logic       pkt_done_q, pkt_done_d;
  logic       parity_err_q, parity_err_d;
  logic       addr_err_q, addr_err_d;
  logic       trunc_err_q, trunc_err_d;
  logic       rd_req;
  logic       abort;

  always_comb begin
    state_d      = state_q;
    issue_cnt_d  = issue_cnt_q;
    recv_cnt_d   = recv_cnt_q;
    par_d        = par_q;
    to_cnt_d     = to_cnt_q;
    pend_d       = 1'b0;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    rx_sop_d     = 1'b0;
    rx_eop_d     = 1'b0;
    rx_len_d     = rx_len_q;
    rx_addr_d    = rx_addr_q;
    pkt_done_d   = 1'b0;
    parity_err_d = 1'b0;
    addr_err_d   = 1'b0;
    trunc_err_d  = 1'b0;
    rd_req       = 1'b0;
    abort        = 1'b0;

    unique case (state_q)
      StIdle: begin
        rd_req = vld_out & ~sink_stall;
        if (rd_req) state_d = StHdr;
      end

      StHdr: begin
        rx_len_d    = data_in[7:2];
        rx_addr_d   = data_in[1:0];
        par_d       = data_in;
        issue_cnt_d = {1'b0, data_in[7:2]} + 7'd1;
        recv_cnt_d  = {1'b0, data_in[7:2]} + 7'd1;
        to_cnt_d    = '0;
        state_d     = StBody;
      end

      StBody: begin
        rd_req = vld_out & ~sink_stall & (issue_cnt_q != 7'd0);
        if (rd_req) issue_cnt_d = issue_cnt_q - 7'd1;
        pend_d = rd_req;

        // Starvation: reads outstanding, sink ready, FIFO empty.
        if (rd_req || sink_stall) begin
          to_cnt_d = '0;
        end else if (issue_cnt_q != 7'd0) begin
          if (to_cnt_q == ToLast) abort = 1'b1;
          else                    to_cnt_d = to_cnt_q + 8'd1;
        end

        if (pend_q) begin
          recv_cnt_d = recv_cnt_q - 7'd1;
          if (recv_cnt_q > 7'd1) begin
            rx_data_d  = data_in;
            rx_valid_d = 1'b1;
            rx_sop_d   = (recv_cnt_q == ({1'b0, rx_len_q} + 7'd1));
            rx_eop_d   = (recv_cnt_q == 7'd2);
            par_d      = par_q ^ data_in;
          end else begin
            pkt_done_d   = 1'b1;
            parity_err_d = (par_q != data_in);
            addr_err_d   = (rx_addr_q != MY_ADDR);
            state_d      = StIdle;
          end
        end

        // No read is in flight when the timeout fires (TIMEOUT >= 2).
        if (abort) begin
          trunc_err_d = 1'b1;
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
          to_cnt_d    = '0;
          pend_d      = 1'b0;
          state_d     = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      issue_cnt_q  <= '0;
      recv_cnt_q   <= '0;
      par_q        <= '0;
      to_cnt_q     <= '0;
      pend_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_sop_q     <= 1'b0;
      rx_eop_q     <= 1'b0;
      rx_len_q     <= '0;
      rx_addr_q    <= '0;
      pkt_done_q   <= 1'b0;
      parity_err_q <= 1'b0;
      addr_err_q   <= 1'b0;
      trunc_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      issue_cnt_q  <= issue_cnt_d;
      recv_cnt_q   <= recv_cnt_d;
      par_q        <= par_d;
      to_cnt_q     <= to_cnt_d;
      pend_q       <= pend_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_sop_q     <= rx_sop_d;
      rx_eop_q     <= rx_eop_d;
      rx_len_q     <= rx_len_d;
      rx_addr_q    <= rx_addr_d;
      pkt_done_q   <= pkt_done_d;
      parity_err_q <= parity_err_d;
      addr_err_q   <= addr_err_d;
      trunc_err_q  <= trunc_err_d;
    end
  end

  // Gated by resetn so the strobe drops immediately while reset is held.
  assign read_enb   = rd_req & resetn;
  assign busy       = (state_q != StIdle);
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_sop     = rx_sop_q;
  assign rx_eop     = rx_eop_q;
  assign rx_len     = rx_len_q;
  assign rx_addr    = rx_addr_q;
  assign pkt_done   = pkt_done_q;
  assign parity_err = parity_err_q;
  assign addr_err   = addr_err_q;
  assign trunc_err  = trunc_err_q;

endmodule

// File: tb/tb_router_pkt_rx.sv
// Bench for router_pkt_rx: a FIFO model feeds packets; a monitor collects the
// payload stream and pulses, which are compared against per-packet expectations.
module tb_router_pkt_rx;

  localparam int unsigned TO = 8;

  logic       clock;
  logic       resetn;
  logic       vld_out;
  logic [7:0] data_in;
  logic       sink_stall;
  logic       read_enb;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_sop;
  logic       rx_eop;
  logic [5:0] rx_len;
  logic [1:0] rx_addr;
  logic       pkt_done;
  logic       parity_err;
  logic       addr_err;
  logic       trunc_err;
  logic       busy;

  router_pkt_rx #(
    .MY_ADDR (2'd1),
    .TIMEOUT (TO)
  ) u_dut (
    .clock      (clock),
    .resetn     (resetn),
    .vld_out    (vld_out),
    .data_in    (data_in),
    .sink_stall (sink_stall),
    .read_enb   (read_enb),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_sop     (rx_sop),
    .rx_eop     (rx_eop),
    .rx_len     (rx_len),
    .rx_addr    (rx_addr),
    .pkt_done   (pkt_done),
    .parity_err (parity_err),
    .addr_err   (addr_err),
    .trunc_err  (trunc_err),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [15:0][7:0] b;        // bytes pushed into the FIFO, b[0] = header
    int               nb;
    int               st_after; // accepted reads before the stall burst (-1: none)
    int               st_cyc;
    int               e_nvalid;
    bit               e_done;
    bit               e_perr;
    bit               e_aerr;
    bit               e_trunc;
    logic [5:0]       e_len;
    logic [1:0]       e_addr;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] fifo [$];
  logic [7:0] mon_data [$];
  bit         mon_sop [$];
  bit         mon_eop [$];
  int         rd_cyc [$];
  int         val_cyc [$];
  int n_done, n_perr, n_aerr, n_trunc, done_cyc, trunc_cyc;
  int cyc = 0;

  bit rnd_mode = 1'b0;
  bit hidden = 1'b0;
  int hide_rem = 0;
  int stall_after = -1;
  int stall_cyc = 0;
  int stall_rem = 0;

  int rd_off [5] = '{0, 2, 3, 4, 5};
  int val_off [3] = '{4, 5, 6};

  vec_t tbl [7];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic vec_t mk(input logic [63:0] seq, input int nb, input int st_after,
                              input int st_cyc, input int e_nvalid, input bit e_done,
                              input bit e_perr, input bit e_aerr, input bit e_trunc,
                              input logic [5:0] e_len, input logic [1:0] e_addr);
    vec_t v;
    v.b = '0;
    for (int i = 0; i < 8; i++) v.b[i] = seq[63-8*i -: 8];
    v.nb = nb;  v.st_after = st_after;  v.st_cyc = st_cyc;
    v.e_nvalid = e_nvalid;  v.e_done = e_done;  v.e_perr = e_perr;
    v.e_aerr = e_aerr;  v.e_trunc = e_trunc;  v.e_len = e_len;  v.e_addr = e_addr;
    return v;
  endfunction

  task automatic mon_clear();
    mon_data.delete();  mon_sop.delete();  mon_eop.delete();
    rd_cyc.delete();  val_cyc.delete();
    n_done = 0;  n_perr = 0;  n_aerr = 0;  n_trunc = 0;  done_cyc = -1;  trunc_cyc = -1;
  endtask

  // One clock: monitor at the falling edge, then update FIFO and stimulus after the rising edge.
  task automatic step();
    bit acc;
    @(negedge clock);
    cyc++;
    check("read_enb gating", int'(read_enb & (~vld_out | sink_stall)), 0);
    if (rx_valid) begin
      mon_data.push_back(rx_data);
      mon_sop.push_back(rx_sop);
      mon_eop.push_back(rx_eop);
      val_cyc.push_back(cyc);
    end
    if (pkt_done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (parity_err) n_perr++;
    if (addr_err) n_aerr++;
    if (trunc_err) begin
      n_trunc++;
      trunc_cyc = cyc;
    end
    acc = read_enb & vld_out;
    if (acc) rd_cyc.push_back(cyc);
    @(posedge clock);
    #1;
    if (acc && fifo.size() != 0) data_in = fifo.pop_front();
    else data_in = 8'($urandom);
    if (rnd_mode) begin
      sink_stall = ($urandom_range(0, 4) == 0);
      if (hide_rem > 0) begin
        hide_rem--;
        hidden = 1'b1;
      end else begin
        hidden = 1'b0;
        if ($urandom_range(0, 5) == 0) hide_rem = $urandom_range(1, 3);
      end
    end else begin
      hidden = 1'b0;
      if (acc && stall_after >= 0 && rd_cyc.size() == stall_after) stall_rem = stall_cyc;
      sink_stall = (stall_rem > 0);
      if (stall_rem > 0) stall_rem--;
    end
    vld_out = (fifo.size() != 0) && !hidden;
  endtask

  task automatic check_pkt(input vec_t v, input string tag);
    int n;
    check({tag, " payload count"}, mon_data.size(), v.e_nvalid);
    n = (mon_data.size() < v.e_nvalid) ? mon_data.size() : v.e_nvalid;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s data[%0d]", tag, i), int'(mon_data[i]), int'(v.b[i+1]));
      check($sformatf("%s sop[%0d]", tag, i), int'(mon_sop[i]), int'(i == 0));
      check($sformatf("%s eop[%0d]", tag, i), int'(mon_eop[i]),
            int'(v.e_done && (i == v.e_nvalid - 1)));
    end
    check({tag, " pkt_done"}, n_done, int'(v.e_done));
    check({tag, " parity_err"}, n_perr, int'(v.e_perr));
    check({tag, " addr_err"}, n_aerr, int'(v.e_aerr));
    check({tag, " trunc_err"}, n_trunc, int'(v.e_trunc));
    check({tag, " rx_len"}, int'(rx_len), int'(v.e_len));
    check({tag, " rx_addr"}, int'(rx_addr), int'(v.e_addr));
    check({tag, " reads"}, rd_cyc.size(), v.nb);
    check({tag, " busy"}, int'(busy), 0);
  endtask

  task automatic run_pkt(input vec_t v, input bit rnd, input string tag);
    bit fin;
    mon_clear();
    rnd_mode = rnd;
    stall_after = v.st_after;
    stall_cyc = v.st_cyc;
    stall_rem = 0;
    for (int i = 0; i < v.nb; i++) fifo.push_back(v.b[i]);
    vld_out = !hidden;
    fin = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (fifo.size() == 0 && !busy) begin
        fin = 1'b1;
        break;
      end
    end
    check({tag, " completes in budget"}, int'(fin), 1);
    step();  // capture the pulses that accompany the return to idle
    check_pkt(v, tag);
    fifo.delete();
    sink_stall = 1'b0;
    vld_out = 1'b0;
  endtask

  initial begin
    vec_t       v;
    int         len;
    logic [1:0] a;
    logic [7:0] par;
    bit         bad;
    bit         seen;

    resetn = 1'b1;
    vld_out = 1'b0;
    sink_stall = 1'b0;
    data_in = 8'h00;
    #1 resetn = 1'b0;
    #1;
    check("reset read_enb", int'(read_enb), 0);
    check("reset busy", int'(busy), 0);
    check("reset rx_valid", int'(rx_valid), 0);
    check("reset pkt_done", int'(pkt_done), 0);
    check("reset rx_len", int'(rx_len), 0);
    check("reset rx_addr", int'(rx_addr), 0);
    check("reset trunc_err", int'(trunc_err), 0);
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;

    //                 bytes (left = first)     nb  stall  nval done perr aerr trunc len addr
    tbl[0] = mk(64'h0DA1_2233_BD00_0000, 5, -1, 0, 3, 1, 0, 0, 0, 6'd3, 2'd1);
    tbl[1] = mk(64'h0DA1_2233_BC00_0000, 5, -1, 0, 3, 1, 1, 0, 0, 6'd3, 2'd1);
    tbl[2] = mk(64'h0101_0000_0000_0000, 2, -1, 0, 0, 1, 0, 0, 0, 6'd0, 2'd1);
    tbl[3] = mk(64'h1910_2030_4050_6069, 8, 3, 4, 6, 1, 0, 0, 0, 6'd6, 2'd1);
    tbl[4] = mk(64'h155A_A500_0000_0000, 3, -1, 0, 2, 0, 0, 0, 1, 6'd5, 2'd1);
    tbl[5] = mk(64'h09C3_3CF6_0000_0000, 4, -1, 0, 2, 1, 0, 0, 0, 6'd2, 2'd1);
    tbl[6] = mk(64'h0E01_0203_0E00_0000, 5, -1, 0, 3, 1, 0, 1, 0, 6'd3, 2'd2);

    for (int i = 0; i < 7; i++) begin
      run_pkt(tbl[i], 1'b0, $sformatf("vec%0d", i));
      // Exact read/output timing of the basic packet.
      if (i == 0 && rd_cyc.size() == 5 && val_cyc.size() == 3) begin
        for (int k = 0; k < 5; k++) check("vec0 read timing", rd_cyc[k] - rd_cyc[0], rd_off[k]);
        for (int k = 0; k < 3; k++) check("vec0 valid timing", val_cyc[k] - rd_cyc[0], val_off[k]);
        check("vec0 done timing", done_cyc - rd_cyc[0], 7);
      end
      // TIMEOUT starved cycles after the last read, pulse one cycle later.
      if (tbl[i].e_trunc && rd_cyc.size() != 0)
        check("trunc latency", trunc_cyc - rd_cyc[$], int'(TO) + 1);
    end

    // Asynchronous reset in the middle of a body.
    mon_clear();
    rnd_mode = 1'b0;
    stall_after = -1;
    for (int i = 0; i < 5; i++) fifo.push_back(tbl[0].b[i]);
    vld_out = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = (mon_data.size() != 0);
    end
    check("reset test reaches body", int'(seen), 1);
    #2 resetn = 1'b0;
    #1;
    check("async reset read_enb", int'(read_enb), 0);
    check("async reset busy", int'(busy), 0);
    check("async reset rx_valid", int'(rx_valid), 0);
    check("async reset rx_len", int'(rx_len), 0);
    fifo.delete();
    vld_out = 1'b0;
    @(posedge clock);
    #3 resetn = 1'b1;
    step();
    check("post reset busy", int'(busy), 0);
    run_pkt(tbl[0], 1'b0, "post reset");

    // Random packets with random stalls and short FIFO gaps.
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(0, 12);
      a = 2'($urandom_range(0, 3));
      bad = ($urandom_range(0, 3) == 0);
      v.b = '0;
      v.b[0] = {6'(len), a};
      par = v.b[0];
      for (int k = 1; k <= len; k++) begin
        v.b[k] = 8'($urandom);
        par = par ^ v.b[k];
      end
      v.b[len+1] = bad ? (par ^ (8'd1 << $urandom_range(0, 7))) : par;
      v.nb = len + 2;
      v.st_after = -1;
      v.st_cyc = 0;
      v.e_nvalid = len;
      v.e_done = 1'b1;
      v.e_perr = bad;
      v.e_aerr = (a != 2'd1);
      v.e_trunc = 1'b0;
      v.e_len = 6'(len);
      v.e_addr = a;
      run_pkt(v, 1'b1, $sformatf("rnd%0d", p));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/router_pkt_rx.md
Name: router_pkt_rx

Overview:
- Packet receiver at the output side of one router destination port; it is the reader for one destination FIFO.
- Drains one packet at a time using vld_out and read_enb, and decodes the header byte: addr in bits [1:0], payload length in bits [7:2].
- Streams payload bytes downstream, checks the trailing parity byte, and flags address errors, parity errors and truncated packets.

Parameters:
MY_ADDR, 2'd0, expected destination address in header bits [1:0]
TIMEOUT, 8, consecutive starved cycles mid-packet before abort (range 2..255)

Ports:
clock  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
vld_out  input  1  FIFO not-empty
data_in  input  8  FIFO data_out; valid only in the cycle after an accepted read
sink_stall  input  1  downstream cannot accept; suppresses new reads
read_enb  output  1  FIFO read strobe
rx_data  output  8  payload byte
rx_valid  output  1  rx_data valid, one cycle per byte
rx_sop  output  1  with rx_valid on first payload byte
rx_eop  output  1  with rx_valid on last payload byte
rx_len  output  6  length of current/last header
rx_addr  output  2  address of current/last header
pkt_done  output  1  one-cycle pulse, packet complete
parity_err  output  1  pulse with pkt_done on parity mismatch
addr_err  output  1  pulse with pkt_done when rx_addr != MY_ADDR
trunc_err  output  1  one-cycle pulse on timeout abort
busy  output  1  high when state != IDLE

Behaviour:
- Reset: all outputs and state cleared to 0 and IDLE immediately, independent of clock.
- Accepted read: read_enb=1 and vld_out=1 at edge T. The byte is sampled from data_in at edge T+1.
- read_enb is combinational from state and vld_out. It is never high when vld_out=0 or sink_stall=1.
- Registered outputs (rx_*, pulses) become visible after the sampling edge, i.e. 2 cycles after the issue cycle.
- IDLE: read_enb = vld_out & !sink_stall. An accepted read moves to HDR. read_enb is low in HDR.
- HDR (byte arriving): latch rx_len=data_in[7:2] and rx_addr=data_in[1:0]. Set par=data_in, issue_cnt=rx_len+1, recv_cnt=rx_len+1 (7-bit counters). Go to BODY.
- BODY, reads:
  - read_enb = vld_out & !sink_stall & (issue_cnt!=0).
  - issue_cnt decrements per accepted read.
  - Back-to-back reads are allowed, giving 1 byte per cycle.
- BODY, each sampled byte:
  - recv_cnt decrements.
  - If recv_cnt > 1 before the decrement: it is a payload byte. Register it to rx_data and pulse rx_valid. Set rx_sop if it is the first payload byte and rx_eop if recv_cnt==2. Update par ^= byte.
  - If recv_cnt == 1: it is the parity byte. Pulse pkt_done, set parity_err=(par!=byte) and addr_err=(rx_addr!=MY_ADDR), then return to IDLE.
  - A new header read may issue in the cycle after the return to IDLE, never earlier.
  - read_enb never exceeds len+2 accepted reads per packet.
- Length 0: header then parity only. No rx_valid is produced and pkt_done still pulses.
- sink_stall affects issue only. A byte already in flight is always delivered, so no data is lost and order is preserved.
- Timeout counter:
  - In BODY, counts cycles with issue_cnt!=0 & !sink_stall & !vld_out.
  - Clears on any accepted read or any stall cycle.
  - On reaching TIMEOUT: pulse trunc_err, no pkt_done, return to IDLE with the counters cleared. Any partial payload already emitted stays emitted, and rx_eop is not generated.
  - The timeout is not active in IDLE or HDR.
- rx_len and rx_addr hold until the next header is latched.

Test Plan:
1. MY_ADDR=1; FIFO holds 0x0D, 0xA1, 0x22, 0x33, 0xBD; no stall -> read_enb high 1 cycle, then 4 consecutive cycles. rx_data A1,22,33 on consecutive cycles, sop on A1, eop on 33. rx_len=3, rx_addr=1. pkt_done with parity_err=0 and addr_err=0.
2. Same packet with parity byte 0xBC -> identical data stream; pkt_done with parity_err=1.
3. FIFO holds 0x05, 0x05 (len 1? no: len=1, addr=1) replaced by 0x01, 0x01 (len 0, addr 1) -> exactly 2 accepted reads, no rx_valid, pkt_done with parity_err=0.
4. len-6 packet with sink_stall=1 for 4 cycles after the 2nd payload read -> read_enb low for those 4 cycles. All 6 bytes are delivered in order, with no duplicates and no drops.
5. TIMEOUT=8; len-5 packet whose FIFO goes empty after 2 payload bytes for 8 cycles -> trunc_err pulses once, busy=0, no pkt_done. A following good packet is received correctly.
6. Header 0x0E (addr 2) with MY_ADDR=1 -> addr_err=1 at pkt_done. Then assert resetn=0 mid-BODY -> read_enb, busy and rx_valid go to 0 asynchronously, and state is IDLE after release.
